// File: rtl/alu_seq_param_if.sv
// Request/result handshake bundle for alu_seq_param.
// Master drives requests and consumes results; slave is the ALU.
interface alu_seq_param_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_A;
  logic [WIDTH-1:0]   in_B;
  logic [3:0]         mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_data;
  logic               out_err;

  modport master (
    output in_valid, in_A, in_B, mode, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_A, in_B, mode, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/alu_seq_param.sv
// Handshaked ALU: 1-cycle ops, iterative mul/div (WIDTH steps).
// Define ALU_SIGNED_EN to add signed mul (11) and signed div (12).
module alu_seq_param #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input logic           clk,
  input logic           rst_n,
  alu_seq_param_if.slave bus
);
  localparam int W = WIDTH;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*W:0]    acc;
  logic [W-1:0]    opb;
  logic [W-1:0]    rem;
  logic [W-1:0]    quo;
  logic            dz;
`ifdef ALU_SIGNED_EN
  logic [W-1:0]    a_q;
  logic            neg_q;
  logic            neg_r;
  logic            ovf;
  logic            sgn;
`endif

  logic [W-1:0]    sum, dif, res, sh_r, sh_l;
  logic            ill, big, is_mul, is_div;
  logic [W-1:0]    mag_a, mag_b;
  logic [W:0]      msum, rsh, rdf;
  logic [2*W:0]    acc_n;
  logic [W-1:0]    rem_n, quo_n;
  logic [2*W-1:0]  mul_res, div_res;

  always_comb begin
    sum  = bus.in_A + bus.in_B;
    dif  = bus.in_A - bus.in_B;
    big  = |bus.in_B[W-1:CW-1];
    sh_r = big ? '0 : bus.in_A >> bus.in_B[CW-2:0];
    sh_l = big ? '0 : bus.in_A << bus.in_B[CW-2:0];
    res  = '0;
    ill  = 1'b0;
    unique case (1'b1)
      (bus.mode == 4'd0): begin
        res = sum;
        if (bus.in_A[W-1] == bus.in_B[W-1] &&
            sum[W-1] != bus.in_A[W-1])
          res = bus.in_A[W-1] ? MIN : MAX;
      end
      (bus.mode == 4'd1): begin
        res = dif;
        if (bus.in_A[W-1] != bus.in_B[W-1] &&
            dif[W-1] != bus.in_A[W-1])
          res = bus.in_A[W-1] ? MIN : MAX;
      end
      (bus.mode == 4'd2): res = bus.in_A & bus.in_B;
      (bus.mode == 4'd3): res = bus.in_A | bus.in_B;
      (bus.mode == 4'd4): res = bus.in_A ^ bus.in_B;
      (bus.mode == 4'd5):
        res[0] = (bus.in_A == bus.in_B);
      (bus.mode == 4'd6):
        res[0] = ($signed(bus.in_A) >= $signed(bus.in_B));
      (bus.mode == 4'd7): res = sh_r;
      (bus.mode == 4'd8): res = sh_l;
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    is_mul = (bus.mode == 4'd9);
    is_div = (bus.mode == 4'd10);
    mag_a  = bus.in_A;
    mag_b  = bus.in_B;
`ifdef ALU_SIGNED_EN
    sgn = (bus.mode == 4'd11) || (bus.mode == 4'd12);
    if (bus.mode == 4'd11) is_mul = 1'b1;
    if (bus.mode == 4'd12) is_div = 1'b1;
    if (sgn && bus.in_A[W-1]) mag_a = -bus.in_A;
    if (sgn && bus.in_B[W-1]) mag_b = -bus.in_B;
`endif
  end

  // acc = {carry, hi, lo}; lo holds the unconsumed multiplier bits
  always_comb begin
    msum  = acc[2*W:W] + (acc[0] ? {1'b0, opb} : '0);
    acc_n = {1'b0, msum, acc[W-1:1]};
    rsh   = {rem, quo[W-1]};
    rdf   = rsh - {1'b0, opb};
    rem_n = rdf[W] ? rsh[W-1:0] : rdf[W-1:0];
    quo_n = {quo[W-2:0], ~rdf[W]};
    mul_res = acc_n[2*W-1:0];
    div_res = {rem_n, quo_n};
`ifdef ALU_SIGNED_EN
    if (neg_q) mul_res = -acc_n[2*W-1:0];
    if (neg_q) div_res[W-1:0] = -quo_n;
    if (neg_r) div_res[2*W-1:W] = -rem_n;
    if (dz) div_res = {a_q, {W{1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      opb           <= '0;
      rem           <= '0;
      quo           <= '0;
      dz            <= 1'b0;
`ifdef ALU_SIGNED_EN
      a_q           <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      ovf           <= 1'b0;
`endif
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.in_ready <= 1'b0;
            cnt          <= '0;
            dz           <= 1'b0;
`ifdef ALU_SIGNED_EN
            a_q   <= bus.in_A;
            neg_q <= sgn & (bus.in_A[W-1] ^ bus.in_B[W-1]);
            neg_r <= sgn & bus.in_A[W-1];
            ovf   <= (bus.mode == 4'd12) &&
                     (bus.in_A == MIN) && (&bus.in_B);
`endif
            if (is_mul) begin
              state <= MUL;
              acc   <= {1'b0, {W{1'b0}}, mag_b};
              opb   <= mag_a;
            end else if (is_div) begin
              state <= DIV;
              rem   <= '0;
              quo   <= mag_a;
              opb   <= mag_b;
              dz    <= ~|bus.in_B;
            end else begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.out_data  <= {{W{1'b0}}, res};
              bus.out_err   <= ill;
            end
          end else begin
            bus.in_ready <= 1'b1;
          end
        end
        MUL: begin
          acc <= acc_n;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.out_data  <= mul_res;
            bus.out_err   <= 1'b0;
          end
        end
        DIV: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.out_data  <= div_res;
`ifdef ALU_SIGNED_EN
            bus.out_err   <= dz | ovf;
`else
            bus.out_err   <= dz;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
